// File: rtl/requantize_stream_top.sv
// Streaming per-channel int32 -> intN requantizer: table read, pre-shift, SRDHM, post-shift + zero-point + clamp.
// Valid/ready: a beat transfers on a cycle where valid && ready; every stage holds while out_valid && !out_ready.
module requantize_stream_top #(
    parameter int LANES = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p_wr_en,
    input  logic [AW-1:0]          p_wr_addr,
    input  logic [LANES*32-1:0]    p_wr_m,
    input  logic [LANES*8-1:0]     p_wr_e,
    input  logic [OUT_W-1:0]       cfg_zp,
    input  logic [OUT_W-1:0]       cfg_min,
    input  logic [OUT_W-1:0]       cfg_max,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [LANES*ACC_W-1:0] in_acc,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic [31:0]            sat_cnt,
    input  logic                   cnt_clr
);
    localparam int CW = $clog2(LANES + 1);
    localparam int GW = 3 * OUT_W;

    function automatic logic [9:0] f_shifts(input logic [7:0] e_raw);
        int e;
        e = int'($signed(e_raw));
        if (e > 31) e = 31;
        if (e < -31) e = -31;
        f_shifts = (e >= 0) ? {5'(e), 5'd0} : {5'd0, 5'(-e)};
    endfunction

    function automatic logic [31:0] f_pre_shift(input logic [31:0] acc, input logic [4:0] l);
        logic signed [63:0] w;
        w = $signed({{32{acc[31]}}, acc}) <<< l;
        if (w > 64'sd2147483647) return 32'h7fffffff;
        if (w < -64'sd2147483648) return 32'h80000000;
        return w[31:0];
    endfunction

    function automatic logic [31:0] f_srdhm(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ab;
        logic signed [63:0] s;
        if (a == 32'h80000000 && b == 32'h80000000) return 32'h7fffffff;
        ab = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        s = ab + ((ab >= 0) ? 64'sd1073741824 : -64'sd1073741823);
        // Bias negatives so the arithmetic shift truncates toward zero.
        if (s < 0) s = s + 64'sd2147483647;
        s = s >>> 31;
        return s[31:0];
    endfunction

    function automatic logic [31:0] f_rdbpot(input logic [31:0] x, input logic [4:0] r);
        logic [31:0] mask;
        logic [31:0] rem;
        logic [31:0] thr;
        logic [31:0] q;
        mask = (32'd1 << r) - 32'd1;
        rem  = x & mask;
        thr  = (mask >> 1) + {31'd0, x[31]};
        q    = $signed(x) >>> r;
        return q + {31'd0, (rem > thr)};
    endfunction

    logic [LANES*32-1:0]    r_mem_m [DEPTH];
    logic [LANES*8-1:0]     r_mem_e [DEPTH];

    logic                   r_run;
    logic [3:0]             r_v;
    logic [LANES*ACC_W-1:0] r_s0_acc;
    logic [LANES*32-1:0]    r_s0_m;
    logic [LANES*8-1:0]     r_s0_e;
    logic [GW-1:0]          r_s0_cfg;
    logic                   r_s0_last;
    logic [LANES*32-1:0]    r_s1_x1;
    logic [LANES*32-1:0]    r_s1_m;
    logic [LANES*5-1:0]     r_s1_r;
    logic [GW-1:0]          r_s1_cfg;
    logic                   r_s1_last;
    logic [LANES*32-1:0]    r_s2_x2;
    logic [LANES*5-1:0]     r_s2_r;
    logic [GW-1:0]          r_s2_cfg;
    logic                   r_s2_last;
    logic [LANES*33-1:0]    r_s3_y;
    logic [2*OUT_W-1:0]     r_s3_mm;
    logic                   r_s3_last;
    logic                   r_out_valid;
    logic [LANES*OUT_W-1:0] r_out_data;
    logic                   r_out_last;
    logic [CW-1:0]          r_out_sat;
    logic [31:0]            r_sat_cnt;

    logic                   w_adv;
    logic                   w_accept;
    logic [LANES*32-1:0]    w_s1_x1;
    logic [LANES*5-1:0]     w_s1_r;
    logic [LANES*32-1:0]    w_s2_x2;
    logic [LANES*33-1:0]    w_s3_y;
    logic [LANES*OUT_W-1:0] w_out_data;
    logic [CW-1:0]          w_out_sat;
    logic [32:0]            w_sat_sum;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = r_run && w_adv;
    assign w_accept  = in_valid && in_ready;
    assign w_sat_sum = {1'b0, r_sat_cnt} + 33'(r_out_sat);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sat_cnt   = r_sat_cnt;

    always_comb begin
        logic [9:0]              v_sh;
        logic [31:0]             v_x3;
        logic signed [32:0]      v_y;
        logic signed [OUT_W-1:0] v_zp;
        logic signed [OUT_W-1:0] v_mn;
        logic signed [OUT_W-1:0] v_mx;
        logic                    v_lo;
        logic                    v_hi;
        w_s1_x1    = '0;
        w_s1_r     = '0;
        w_s2_x2    = '0;
        w_s3_y     = '0;
        w_out_data = '0;
        w_out_sat  = '0;
        v_zp = $signed(r_s2_cfg[2*OUT_W +: OUT_W]);
        v_mn = $signed(r_s3_mm[OUT_W +: OUT_W]);
        v_mx = $signed(r_s3_mm[0 +: OUT_W]);
        for (int k = 0; k < LANES; k++) begin
            v_sh = f_shifts(r_s0_e[k*8 +: 8]);
            w_s1_x1[k*32 +: 32] = f_pre_shift(r_s0_acc[k*ACC_W +: 32], v_sh[9:5]);
            w_s1_r[k*5 +: 5]    = v_sh[4:0];
            w_s2_x2[k*32 +: 32] = f_srdhm(r_s1_x1[k*32 +: 32], r_s1_m[k*32 +: 32]);
            v_x3 = f_rdbpot(r_s2_x2[k*32 +: 32], r_s2_r[k*5 +: 5]);
            w_s3_y[k*33 +: 33] = $signed({v_x3[31], v_x3}) + 33'(v_zp);
            v_y  = $signed(r_s3_y[k*33 +: 33]);
            v_lo = v_y < 33'(v_mn);
            v_hi = v_y > 33'(v_mx);
            // An inverted window (min > max) pins every lane to max.
            if (v_mn > v_mx)
                w_out_data[k*OUT_W +: OUT_W] = v_mx;
            else if (v_lo)
                w_out_data[k*OUT_W +: OUT_W] = v_mn;
            else if (v_hi)
                w_out_data[k*OUT_W +: OUT_W] = v_mx;
            else
                w_out_data[k*OUT_W +: OUT_W] = v_y[OUT_W-1:0];
            w_out_sat = w_out_sat + CW'(v_lo || v_hi);
        end
    end

    // Parameter table: read-first, so a same-cycle write to the read address returns the old entry.
    always_ff @(posedge clk) begin
        if (p_wr_en) begin
            r_mem_m[p_wr_addr] <= p_wr_m;
            r_mem_e[p_wr_addr] <= p_wr_e;
        end
        if (w_adv) begin
            r_s0_m <= r_mem_m[in_addr];
            r_s0_e <= r_mem_e[in_addr];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_run       <= 1'b0;
            r_v         <= '0;
            r_s0_acc    <= '0;
            r_s0_cfg    <= '0;
            r_s0_last   <= 1'b0;
            r_s1_x1     <= '0;
            r_s1_m      <= '0;
            r_s1_r      <= '0;
            r_s1_cfg    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_x2     <= '0;
            r_s2_r      <= '0;
            r_s2_cfg    <= '0;
            r_s2_last   <= 1'b0;
            r_s3_y      <= '0;
            r_s3_mm     <= '0;
            r_s3_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= '0;
            r_sat_cnt   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_adv) begin
                r_v         <= {r_v[2:0], w_accept};
                r_s0_acc    <= in_acc;
                r_s0_cfg    <= {cfg_zp, cfg_min, cfg_max};
                r_s0_last   <= in_last;
                r_s1_x1     <= w_s1_x1;
                r_s1_m      <= r_s0_m;
                r_s1_r      <= w_s1_r;
                r_s1_cfg    <= r_s0_cfg;
                r_s1_last   <= r_s0_last;
                r_s2_x2     <= w_s2_x2;
                r_s2_r      <= r_s1_r;
                r_s2_cfg    <= r_s1_cfg;
                r_s2_last   <= r_s1_last;
                r_s3_y      <= w_s3_y;
                r_s3_mm     <= r_s2_cfg[0 +: 2*OUT_W];
                r_s3_last   <= r_s2_last;
                r_out_valid <= r_v[3];
                r_out_data  <= w_out_data;
                r_out_last  <= r_s3_last;
                r_out_sat   <= w_out_sat;
            end
            if (cnt_clr)
                r_sat_cnt <= '0;
            else if (r_out_valid && out_ready)
                r_sat_cnt <= w_sat_sum[32] ? 32'hffffffff : w_sat_sum[31:0];
        end
    end
endmodule

// File: tb/tb_requantize_stream_top.sv
// Bench for requantize_stream_top: directed beats checked against an arithmetic model and a few literal values.
module tb_requantize_stream_top;
    localparam int LANES = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int DW    = LANES * OUT_W;
    localparam int EW    = DW + 1 + 8;
    localparam longint I32_MAX = 64'sd2147483647;
    localparam longint I32_MIN = -64'sd2147483648;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   p_wr_en = 1'b0;
    logic [AW-1:0]          p_wr_addr = '0;
    logic [LANES*32-1:0]    p_wr_m = '0;
    logic [LANES*8-1:0]     p_wr_e = '0;
    logic [OUT_W-1:0]       cfg_zp = '0;
    logic [OUT_W-1:0]       cfg_min = 8'h80;
    logic [OUT_W-1:0]       cfg_max = 8'h7f;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [AW-1:0]          in_addr = '0;
    logic [LANES*ACC_W-1:0] in_acc = '0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [DW-1:0]          out_data;
    logic                   out_last;
    logic [31:0]            sat_cnt;
    logic                   cnt_clr = 1'b0;

    requantize_stream_top #(.LANES(LANES), .DEPTH(DEPTH), .AW(AW), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr), .p_wr_m(p_wr_m),
        .p_wr_e(p_wr_e), .cfg_zp(cfg_zp), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_acc(in_acc),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int                  n_vec = 0;
    int                  n_fail = 0;
    logic [EW-1:0]       exp_q[$];
    logic [LANES*32-1:0] m_tab[DEPTH];
    logic [LANES*8-1:0]  e_tab[DEPTH];
    logic [31:0]         exp_sat = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_lane(input logic [31:0] acc, input logic [31:0] m, input logic [7:0] e8,
                                       input logic [OUT_W-1:0] zp, input logic [OUT_W-1:0] mn,
                                       input logic [OUT_W-1:0] mx, output logic [OUT_W-1:0] o,
                                       output bit sat);
        longint x1, ab, x2, mask, rem, thr, x3, y, lo, hi, mm;
        int e, l, r;
        e = int'($signed(e8));
        if (e > 31) e = 31;
        if (e < -31) e = -31;
        l = (e > 0) ? e : 0;
        r = (e < 0) ? -e : 0;
        x1 = longint'($signed(acc)) * (longint'(1) << l);
        if (x1 > I32_MAX) x1 = I32_MAX;
        if (x1 < I32_MIN) x1 = I32_MIN;
        mm = longint'($signed(m));
        if (x1 == I32_MIN && mm == I32_MIN) x2 = I32_MAX;
        else begin
            ab = x1 * mm;
            x2 = (ab + ((ab >= 0) ? (longint'(1) << 30) : (1 - (longint'(1) << 30)))) / (longint'(1) << 31);
        end
        mask = (longint'(1) << r) - 1;
        rem  = x2 & mask;
        thr  = (mask >>> 1) + ((x2 < 0) ? 1 : 0);
        x3   = (x2 >>> r) + ((rem > thr) ? 1 : 0);
        y    = x3 + longint'($signed(zp));
        lo   = longint'($signed(mn));
        hi   = longint'($signed(mx));
        sat  = (y < lo) || (y > hi);
        if (lo > hi) o = mx;
        else if (y < lo) o = mn;
        else if (y > hi) o = mx;
        else o = y[OUT_W-1:0];
    endfunction

    function automatic void model_beat(input logic [AW-1:0] a, input logic [LANES*32-1:0] acc,
                                       input logic [OUT_W-1:0] zp, input logic [OUT_W-1:0] mn,
                                       input logic [OUT_W-1:0] mx, output logic [DW-1:0] d,
                                       output logic [7:0] nsat);
        logic [OUT_W-1:0] o;
        bit s;
        nsat = 0;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            model_lane(acc[k*32 +: 32], m_tab[a][k*32 +: 32], e_tab[a][k*8 +: 8], zp, mn, mx, o, s);
            d[k*OUT_W +: OUT_W] = o;
            nsat = nsat + 8'(s);
        end
    endfunction

    function automatic logic [LANES*32-1:0] rep32(input logic [31:0] v);
        for (int k = 0; k < LANES; k++) rep32[k*32 +: 32] = v;
    endfunction

    function automatic logic [LANES*8-1:0] rep8(input logic [7:0] v);
        for (int k = 0; k < LANES; k++) rep8[k*8 +: 8] = v;
    endfunction

    function automatic logic [LANES*32-1:0] ramp(input int base, input int step);
        for (int k = 0; k < LANES; k++) ramp[k*32 +: 32] = 32'(base + k * step);
    endfunction

    // Compare process: scoreboard, hold-stability and sat_cnt model, all sampled on the falling edge.
    logic [EW-1:0] e_item;
    logic [DW-1:0] held_data;
    logic          held_last;
    bit            held = 0;
    logic [DW-1:0] md;
    logic [7:0]    ms;
    logic [7:0]    s_pop;
    logic [32:0]   s_sum;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_q.delete();
            exp_sat = '0;
            held = 0;
        end else begin
            check("sat_cnt", sat_cnt, exp_sat);
            if (held) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {out_last, out_data}, {held_last, held_data});
            end
            s_pop = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %h expected no beat at %0t", out_data, $time);
                end else begin
                    e_item = exp_q.pop_front();
                    check("out_data", out_data, e_item[DW-1:0]);
                    check("out_last", out_last, e_item[DW]);
                    s_pop = e_item[EW-1 -: 8];
                end
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (cnt_clr) exp_sat = '0;
            else if (out_valid && out_ready) begin
                s_sum = {1'b0, exp_sat} + 33'(s_pop);
                exp_sat = s_sum[32] ? 32'hffffffff : s_sum[31:0];
            end
            if (in_valid && in_ready) begin
                model_beat(in_addr, in_acc, cfg_zp, cfg_min, cfg_max, md, ms);
                exp_q.push_back({ms, in_last, md});
            end
        end
        if (p_wr_en) begin
            m_tab[p_wr_addr] = p_wr_m;
            e_tab[p_wr_addr] = p_wr_e;
        end
    end

    // Driver tasks start and end in the drive slot, two time units after a rising edge.
    task automatic write_entry(input logic [AW-1:0] a, input logic [LANES*32-1:0] m, input logic [LANES*8-1:0] e);
        p_wr_en = 1'b1; p_wr_addr = a; p_wr_m = m; p_wr_e = e;
        @(posedge clk); #2;
        p_wr_en = 1'b0;
    endtask

    task automatic send_beat(input logic [AW-1:0] a, input logic [LANES*32-1:0] acc, input logic [7:0] zp,
                             input logic [7:0] mn, input logic [7:0] mx, input logic last);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_addr = a; in_acc = acc; cfg_zp = zp; cfg_min = mn; cfg_max = mx; in_last = last;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #2;
            p_wr_en = 1'b0;
        end
        check("accept", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [OUT_W-1:0] po;
    bit               ps;
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_data", {out_last, out_data}, '0);
        check("rst_sat_cnt", sat_cnt, '0);
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        check("in_ready_after_release", in_ready, 1'b1);

        // Literal pins of the model.
        model_lane(32'd100, 32'h40000000, 8'd0, 8'd37, 8'h80, 8'h7f, po, ps);
        check("pin_t1", {ps, po}, {1'b0, 8'd87});
        model_lane(32'd1000, 32'h40000000, 8'hfe, 8'd37, 8'h80, 8'h7f, po, ps);
        check("pin_t2", {ps, po}, {1'b1, 8'd127});
        model_lane(32'd5, 32'h40000000, 8'hff, 8'd0, 8'h80, 8'h7f, po, ps);
        check("pin_t3a", po, 8'd2);
        model_lane(32'd10, 32'h40000000, 8'd1, 8'd37, 8'h80, 8'h7f, po, ps);
        check("pin_t3b", po, 8'd47);
        model_lane(32'd100, 32'h20000000, 8'd0, 8'd0, 8'h80, 8'h7f, po, ps);
        check("pin_t5", po, 8'd25);
        model_lane(-32'sd1000, 32'h40000000, 8'hfe, 8'd0, 8'h80, 8'h7f, po, ps);
        check("pin_neg", po, 8'h83);
        model_lane(32'd100, 32'h40000000, 8'd0, 8'd0, 8'd10, 8'hf6, po, ps);
        check("pin_inverted", {ps, po}, {1'b1, 8'hf6});

        write_entry(0, rep32(32'h40000000), rep8(8'd0));
        write_entry(1, rep32(32'h40000000), rep8(8'hfe));
        write_entry(2, rep32(32'h40000000), rep8(8'hff));
        write_entry(3, rep32(32'h40000000), rep8(8'd1));
        write_entry(4, {32'h40000001, 32'h80000000, 32'h7fffffff, 32'h40000000}, {8'he1, 8'd5, 8'hd8, 8'd40});
        write_entry(5, rep32(32'h40000000), rep8(8'd0));
        write_entry(6, rep32(32'h80000000), rep8(8'd0));

        // T1 with exact latency.
        send_beat(0, rep32(32'd100), 8'd37, 8'h80, 8'h7f, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("t1_not_yet", out_valid, 1'b0);
        @(posedge clk);
        #1 check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, {LANES{8'd87}});
        #1;
        send_beat(1, rep32(32'd1000), 8'd37, 8'h80, 8'h7f, 1'b0);
        idle(6);
        check("t2_sat_cnt", sat_cnt, 32'd4);
        send_beat(2, rep32(32'd5), 8'd0, 8'h80, 8'h7f, 1'b0);
        send_beat(3, rep32(32'd10), 8'd37, 8'h80, 8'h7f, 1'b1);
        send_beat(1, ramp(-1000, -333), 8'd0, 8'h80, 8'h7f, 1'b0);
        send_beat(4, {32'd99999, 32'h80000000, 32'd123456, -32'sd7}, 8'hfb, 8'h9c, 8'd100, 1'b0);
        send_beat(0, rep32(32'd100), 8'd0, 8'd10, 8'hf6, 1'b1);
        send_beat(6, {-32'sd1, 32'd1, 32'h80000000, 32'h80000000}, 8'd3, 8'h80, 8'h7f, 1'b0);
        send_beat(4, ramp(-50000, 40000), 8'd0, 8'h80, 8'h7f, 1'b1);
        idle(6);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;

        // T4: stall the output while six beats are offered back to back.
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(AW'(i % 4), ramp(10 * i - 20, 7), 8'(i), 8'h80, 8'h7f, i == 5);
            end
            begin
                out_ready = 1'b0;
                repeat (8) @(posedge clk);
                #1 check("t4_in_ready_low", in_ready, 1'b0);
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        idle(8);

        // Intermittent downstream readiness with config changes every beat and a counter clear.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat(AW'(i % 5), ramp(300 * i - 900, 250), 8'(i * 9), 8'(-60 + i), 8'(40 + i), i[0]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = (c % 3) != 1;
                    cnt_clr = (c == 5);
                    idle(1);
                end
                out_ready = 1'b1;
                cnt_clr = 1'b0;
            end
        join
        idle(8);

        // T5: write collides with the read of the same entry.
        p_wr_en = 1'b1; p_wr_addr = 5; p_wr_m = rep32(32'h20000000); p_wr_e = rep8(8'd0);
        send_beat(5, rep32(32'd100), 8'd0, 8'h80, 8'h7f, 1'b0);
        send_beat(5, rep32(32'd100), 8'd0, 8'h80, 8'h7f, 1'b1);
        idle(4);
        #1 check("t5_second", out_data, {LANES{8'd25}});
        #1;
        idle(3);

        // T6: reset with beats in flight.
        for (int i = 0; i < 5; i++) send_beat(1, ramp(2000 + 100 * i, 50), 8'd0, 8'h80, 8'h7f, 1'b0);
        check("t6_busy", out_valid, 1'b1);
        rst_n = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_sat_cnt", sat_cnt, '0);
        check("t6_in_ready", in_ready, 1'b0);
        #1;
        idle(2);
        rst_n = 1'b0;
        idle(12);
        send_beat(3, rep32(32'd10), 8'd37, 8'h80, 8'h7f, 1'b1);
        idle(8);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
